// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared width default and FSM state encoding for the sequential divider
package seq_div_pkg;

    localparam int SEQ_DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_CALC   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - operand bus and result signals of the sequential divider
interface seq_divider_if
    import seq_div_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, data_in,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, data_in,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_div_ctrl.sv
// rtl/seq_div_ctrl.sv - control FSM sequencing operand load, repeated subtraction and completion
module seq_div_ctrl
    import seq_div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic div_zero,
    input  logic rem_ge,
    output logic load_a,
    output logic load_b,
    output logic sub_en,
    output logic busy,
    output logic done
);

    state_t state;

    // Datapath strobes are pure state decodes gated by the qualifying flag.
    assign load_a = (state == ST_IDLE) && start;
    assign load_b = (state == ST_LOAD_B);
    assign sub_en = (state == ST_CALC) && rem_ge;

    // busy/done are registered alongside the state so they never see input glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD_B;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD_B: begin
                    if (div_zero) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (!rem_ge) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned divider by repeated subtraction over a shared operand bus
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
    logic             div_zero;
    logic             rem_ge;
    logic             load_a;
    logic             load_b;
    logic             sub_en;

    assign div_zero = (bus.data_in == '0);
    assign rem_ge   = (remainder_q >= divisor_q);

    seq_div_ctrl u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (bus.start),
        .div_zero (div_zero),
        .rem_ge   (rem_ge),
        .load_a   (load_a),
        .load_b   (load_b),
        .sub_en   (sub_en),
        .busy     (bus.busy),
        .done     (bus.done)
    );

    // Remainder starts as the dividend; the quotient counts subtractions and cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            if (load_a) begin
                remainder_q <= bus.data_in;
                quotient_q  <= '0;
                dbz_q       <= 1'b0;
            end
            if (load_b) begin
                divisor_q <= bus.data_in;
                if (div_zero) begin
                    quotient_q <= '1;
                    dbz_q      <= 1'b1;
                end
            end
            if (sub_en) begin
                remainder_q <= remainder_q - divisor_q;
                quotient_q  <= quotient_q + 1'b1;
            end
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench with expected-result scoreboard
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(16)) bus ();

    seq_divider #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit pulse);
        exp_t e;
        exp_t got;
        int   n;
        bit   busy_ok;
        e.dbz = (b == 16'd0);
        e.q   = e.dbz ? 16'hFFFF : a / b;
        e.r   = e.dbz ? a : a % b;
        e.lat = e.dbz ? 1 : int'(e.q) + 2;
        sb.push_back(e);

        bus.start   = 1'b1;
        bus.data_in = a;
        step();
        busy_ok     = (bus.busy === 1'b1);
        bus.start   = pulse;
        bus.data_in = b;
        n = 0;
        do begin
            step();
            n++;
            bus.data_in = 16'($urandom);
            bus.start   = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end while (bus.done !== 1'b1 && n < 70000);

        got = sb.pop_front();
        check("done_seen", 32'(bus.done), 32'd1);
        check("latency", 32'(n), 32'(got.lat));
        check("busy_during_op", 32'(busy_ok), 32'd1);
        check("quotient", 32'(bus.quotient), 32'(got.q));
        check("remainder", 32'(bus.remainder), 32'(got.r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(got.dbz));

        // A start during the DONE cycle must be ignored.
        bus.start = pulse;
        step();
        bus.start = 1'b0;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("idle_after_done", 32'(bus.busy), 32'd0);
        check("quotient_held", 32'(bus.quotient), 32'(got.q));
        check("remainder_held", 32'(bus.remainder), 32'(got.r));
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        do_op(16'd17, 16'd5, 1'b0);
        do_op(16'd4, 16'd9, 1'b0);
        do_op(16'd20, 16'd5, 1'b0);
        do_op(16'd7, 16'd7, 1'b0);
        do_op(16'h1234, 16'd0, 1'b0);
        do_op(16'd9, 16'd3, 1'b0);
        do_op(16'hFFFF, 16'd1, 1'b1);

        // Reset asserted for one edge in the middle of CALC.
        bus.start   = 1'b1;
        bus.data_in = 16'd1000;
        step();
        bus.start   = 1'b0;
        bus.data_in = 16'd3;
        step();
        repeat (5) step();
        check("calc_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_quotient", 32'(bus.quotient), 32'd0);
        check("midrst_remainder", 32'(bus.remainder), 32'd0);
        check("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        step();
        check("midrst_idle", 32'(bus.busy), 32'd0);

        do_op(16'd10, 16'd4, 1'b0);

        do_op(16'd17, 16'd5, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.data_in = 16'($urandom);
            step();
            check("hold_quotient", 32'(bus.quotient), 32'd3);
            check("hold_remainder", 32'(bus.remainder), 32'd2);
            check("hold_busy", 32'(bus.busy), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Unsigned sequential divider that divides by repeated subtraction. It is the inverse companion of the repeated-addition multiplier datapath.
- Operands arrive one per cycle on a single shared data bus: dividend first, then divisor.
- An internal FSM controls a datapath of a remainder register, a quotient counter, a divisor register and a subtract/compare unit.
- Results are held stable, with a one-cycle done pulse, until the next start.

Parameters:
- WIDTH, 16, operand/result width in bits (quotient, remainder, dividend, divisor all WIDTH).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  in IDLE, qualifies data_in as the dividend.
- data_in  in  WIDTH  shared operand bus: dividend on start cycle, divisor on the following cycle.
- busy  out  1  high whenever FSM is not IDLE.
- done  out  1  one-cycle pulse; results valid from this cycle onward.
- quotient  out  WIDTH  result quotient; held until next accepted start.
- remainder  out  WIDTH  result remainder; held until next accepted start.
- div_by_zero  out  1  set with done when divisor was 0; held until next accepted start.

Behaviour:
- Reset: one clock, one synchronous active-high reset (rst) sampled on clk rising edge. rst=1 at any edge, including mid-operation, forces:
  - state IDLE
  - quotient=0, remainder=0, div_by_zero=0, done=0, busy=0
  - internal divisor register=0
  - rst has priority over all other inputs.
- State IDLE: busy=0.
  - start=1 at an edge: remainder<=data_in, quotient<=0, div_by_zero<=0, go LOAD_B.
  - start=0: hold everything.
- State LOAD_B: data_in is sampled unconditionally at the edge into the divisor register.
  - If data_in==0: quotient<=all-ones, remainder unchanged (=dividend), div_by_zero<=1, go DONE.
  - Otherwise go CALC.
- State CALC: each edge compares remainder >= divisor (unsigned, full WIDTH).
  - True: remainder<=remainder-divisor, quotient<=quotient+1, stay in CALC.
  - False: go DONE, registers unchanged.
- State DONE: done=1 for exactly this cycle; next edge returns to IDLE. Outputs hold their values.
- busy=1 in LOAD_B, CALC and DONE. done and busy are decoded from the state register, with no combinational path from inputs.
- Latency: start edge = E0, divisor edge = E1, Q subtraction edges E2..E(Q+1), exit edge E(Q+2).
  - done is high in the cycle after E(Q+2).
  - Divide-by-zero: done is high after E1.
- Worst case: dividend=2^WIDTH-1, divisor=1 gives Q=2^WIDTH-1 subtractions. The quotient counter never wraps because Q is bounded by the dividend.
- start is ignored while busy=1, including in the DONE cycle.
- Subtraction never underflows: it is performed only when remainder >= divisor.
- Equal operands: one subtraction, giving Q=1, R=0.
- Dividend < divisor: zero subtractions, giving Q=0, R=dividend; done high after E2.

Decomposition:
- Shared package seq_div_pkg holds:
  - WIDTH default
  - state encoding constants ST_IDLE, ST_LOAD_B, ST_CALC, ST_DONE (2-bit)
- One sub-module, seq_div_ctrl: the FSM.
  - Inputs: start, divisor-zero flag, remainder>=divisor flag.
  - Outputs: load/decrement/clear controls, busy, done.
- The top level contains the datapath registers, subtractor and comparator.

Test Plan:
- Reset, then start=1 with data_in=17, then data_in=5 -> Q=3, R=2, div_by_zero=0; done high exactly one cycle, in the cycle after the 6th edge counted from the start edge; busy high from E0 through the done cycle.
- 4 / 9 -> Q=0, R=4, done after E2; also 20 / 5 -> Q=4, R=0; also 7 / 7 -> Q=1, R=0.
- 0x1234 / 0 -> div_by_zero=1, Q=0xFFFF, R=0x1234, done after E1; next op 9 / 3 clears div_by_zero and gives Q=3, R=0.
- 0xFFFF / 1 -> Q=0xFFFF, R=0, done after E65537, no wrap; start pulses during busy, including the DONE cycle, produce no restart and no change of result.
- 1000 / 3, with rst=1 asserted for one edge during CALC -> next cycle all outputs 0, state IDLE; a subsequent 10 / 4 gives Q=2, R=2 with correct timing.
- Results held: after done for 17 / 5, idle 20 cycles with random data_in and start=0 -> Q=3, R=2 remain stable.
